// File: rtl/param_acc_processor_if.sv
// Host-facing port bundle of the accumulator processor: serial frame link, run control and status.
interface param_acc_processor_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              run;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic [DATA_W-1:0] acc_out;
  logic [ADDR_W-1:0] pc_out;
  logic [15:0]       cycle_cnt;

  modport master (
    output cs_n, mosi, run,
    input  miso, busy, done, frame_err, acc_out, pc_out, cycle_cnt
  );

  modport slave (
    input  cs_n, mosi, run,
    output miso, busy, done, frame_err, acc_out, pc_out, cycle_cnt
  );
endinterface

// File: rtl/param_acc_processor.sv
// Serial-loaded accumulator processor: host frames fill imem/dmem or queue a dmem readback;
// a run request then executes one instruction per clk until HALT, end of imem, or run falling.
module param_acc_processor #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_acc_processor_if.slave  bus
);
  localparam int INST_W  = ADDR_W + 4;
  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {IDLE, RECV, COMMIT, RUN, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [ADDR_W-1:0]  pc;
  logic [15:0]        cyc;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bitcnt;
  logic [DATA_W-1:0]  tx;
  logic               busy_q;
  logic               done_q;
  logic               ferr_q;

  logic [INST_W-1:0]  imem [DEPTH];
  logic [DATA_W-1:0]  dmem [DEPTH];

  logic [1:0]         f_cmd;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic               commit_ok;

  assign f_cmd     = shreg[FRAME_W-1 -: 2];
  assign f_addr    = shreg[DATA_W +: ADDR_W];
  assign f_data    = shreg[DATA_W-1:0];
  assign commit_ok = (state == COMMIT) && (bitcnt == CNT_FULL);

  logic [INST_W-1:0]  inst;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  operand;
  logic [DATA_W-1:0]  sext;
  logic [DATA_W-1:0]  mem_rd;
  logic [DATA_W-1:0]  acc_nxt;
  logic               taken;
  logic               exec;

  assign inst    = imem[pc];
  assign opcode  = inst[3:0];
  assign operand = inst[INST_W-1:4];
  assign sext    = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};
  assign mem_rd  = dmem[operand];
  assign exec    = (state == RUN) && bus.run;

  // Branches only read acc, so acc_nxt and taken never both change for one opcode.
  always_comb begin
    acc_nxt = acc;
    taken   = 1'b0;
    case (opcode)
      4'h0: acc_nxt = acc + mem_rd;
      4'h1: acc_nxt = acc - mem_rd;
      4'h2: acc_nxt = acc & mem_rd;
      4'h3: acc_nxt = acc ^ mem_rd;
      4'h4: acc_nxt = mem_rd;
      4'h6: acc_nxt = acc + sext;
      4'h7: acc_nxt = sext;
      4'h8: acc_nxt = {acc[DATA_W-2:0], 1'b0};
      4'h9: acc_nxt = {1'b0, acc[DATA_W-1:1]};
      4'hA: taken   = (acc != '0);
      4'hB: taken   = (acc == '0);
      4'hC: taken   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit_ok && f_cmd == 2'b00)
      imem[f_addr] <= f_data[INST_W-1:0];
    if (commit_ok && f_cmd == 2'b01)
      dmem[f_addr] <= f_data;
    else if (exec && opcode == 4'h5)
      dmem[operand] <= acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      pc     <= '0;
      cyc    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      tx     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The edge that opens a frame already captures its first bit.
          if (!bus.cs_n) begin
            state  <= RECV;
            busy_q <= 1'b1;
            ferr_q <= 1'b0;
            shreg  <= {{(FRAME_W-1){1'b0}}, bus.mosi};
            bitcnt <= CNT_W'(1);
          end else if (bus.run) begin
            state  <= RUN;
            busy_q <= 1'b1;
            pc     <= '0;
            acc    <= '0;
            cyc    <= '0;
          end
        end
        RECV: begin
          if (!bus.cs_n) begin
            shreg <= {shreg[FRAME_W-2:0], bus.mosi};
            tx    <= {tx[DATA_W-2:0], 1'b0};
            if (bitcnt != CNT_SAT)
              bitcnt <= bitcnt + CNT_W'(1);
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (bitcnt != CNT_FULL)
            ferr_q <= 1'b1;
          else if (f_cmd == 2'b10)
            tx <= dmem[f_addr];
        end
        RUN: begin
          if (!bus.run) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            pc     <= '0;
          end else begin
            acc <= acc_nxt;
            if (cyc != 16'hFFFF)
              cyc <= cyc + 16'd1;
            if (opcode == 4'hD || (!taken && pc == PC_LAST)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else if (taken) begin
              pc <= operand;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (!bus.run) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso      = (state == RECV) && tx[DATA_W-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.acc_out   = acc;
  assign bus.pc_out    = pc;
  assign bus.cycle_cnt = cyc;
endmodule

// File: tb/tb_param_acc_processor.sv
// Bench for param_acc_processor: directed scenarios plus random programs against an ISA-level model.
module tb_param_acc_processor;
  logic clk = 1'b0;
  logic rst_n;

  param_acc_processor_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  param_acc_processor #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [7:0]  acc;
    logic [3:0]  pc;
    logic [15:0] cnt;
  } snap_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_imem [16];
  int          m_dmem [16];
  int          m_tx    = 0;
  bit          m_err   = 1'b0;
  logic [31:0] last_rx;
  snap_t       q_exp [$];
  snap_t       cur;
  bit          chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t mk(input bit b, input bit d, input int a, input int p, input int c);
    snap_t s;
    s.busy = b;
    s.done = d;
    s.acc  = 8'(a);
    s.pc   = 4'(p);
    s.cnt  = 16'(c);
    return s;
  endfunction

  function automatic logic [31:0] frm(input logic [1:0] c, input logic [3:0] a, input logic [7:0] d);
    return {18'b0, c, a, d};
  endfunction

  // One comparison point per cycle while a run is being tracked.
  always @(negedge clk) begin
    if (chk_on && q_exp.size() > 0) begin
      cur = q_exp.pop_front();
      check("run_busy", bus.busy, cur.busy);
      check("run_done", bus.done, cur.done);
      check("run_acc", bus.acc_out, cur.acc);
      check("run_pc", bus.pc_out, cur.pc);
      check("run_cnt", bus.cycle_cnt, cur.cnt);
    end
  end

  // ISA-level reference: plays the program and queues the expected per-cycle view.
  task automatic model_run(input int limit, output int n_exec, output bit fin);
    int pc, acc, cnt, inst, op, opd, sx, d;
    bit jump;
    pc = 0; acc = 0; cnt = 0; fin = 1'b0;
    q_exp.push_back(mk(1, 0, 0, 0, 0));
    while (!fin && cnt < limit) begin
      inst = m_imem[pc];
      op   = inst % 16;
      opd  = inst / 16;
      sx   = (opd >= 8) ? opd - 16 : opd;
      d    = m_dmem[opd];
      jump = 1'b0;
      case (op)
        0:  acc = acc + d;
        1:  acc = acc - d;
        2:  acc = acc & d;
        3:  acc = acc ^ d;
        4:  acc = d;
        5:  m_dmem[opd] = acc;
        6:  acc = acc + sx;
        7:  acc = sx;
        8:  acc = acc * 2;
        9:  acc = acc / 2;
        10: jump = (acc != 0);
        11: jump = (acc == 0);
        12: jump = 1'b1;
        default: ;
      endcase
      acc = acc & 255;
      cnt++;
      if (op == 13) fin = 1'b1;
      else if (jump) pc = opd;
      else if (pc == 15) fin = 1'b1;
      else pc++;
      q_exp.push_back(mk(!fin, fin, acc, pc, cnt));
    end
    if (fin) q_exp.push_back(mk(0, 1, acc, pc, cnt));
    else     q_exp.push_back(mk(0, 0, acc, 0, cnt));
    n_exec = cnt;
  endtask

  task automatic send_frame(input logic [31:0] val, input int n);
    logic [31:0] rxw, exp_w;
    logic [7:0]  txb;
    logic [3:0]  fa;
    txb = 8'(m_tx);
    rxw = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) rxw[32-i] = bus.miso;
      bus.cs_n = 1'b0;
      bus.mosi = val[n-1-i];
    end
    @(negedge clk);
    rxw[32-n] = bus.miso;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    exp_w = '0;
    for (int i = 0; i < 8 && i < n; i++) exp_w[31-i] = txb[7-i];
    m_tx  = (m_tx << (n - 1)) & 255;
    m_err = (n != 14);
    fa    = val[11:8];
    if (n == 14) begin
      case (val[13:12])
        2'b00:   m_imem[fa] = int'(val[7:0]);
        2'b01:   m_dmem[fa] = int'(val[7:0]);
        2'b10:   m_tx = m_dmem[fa];
        default: ;
      endcase
    end
    last_rx = rxw;
    check("frame_miso", rxw, exp_w);
    check("frame_err", bus.frame_err, m_err);
    check("frame_busy", bus.busy, 0);
  endtask

  task automatic do_run(input int limit, output int n, output bit fin);
    q_exp.delete();
    model_run(limit, n, fin);
    @(negedge clk);
    bus.run = 1'b1;
    #1 chk_on = 1'b1;
    if (!fin) begin
      repeat (n + 1) @(negedge clk);
      bus.run = 1'b0;
    end
    for (int k = 0; k < limit + 20 && q_exp.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("run_drain", q_exp.size(), 0);
    chk_on = 1'b0;
  endtask

  task automatic end_run();
    bus.run = 1'b0;
    @(negedge clk);
    check("post_done", bus.done, 0);
    check("post_busy", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc"}, bus.acc_out, 0);
    check({tag, "_pc"}, bus.pc_out, 0);
    check({tag, "_cnt"}, bus.cycle_cnt, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_ferr"}, bus.frame_err, 0);
    check({tag, "_miso"}, bus.miso, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  fin;
    logic [3:0] ra;
    int  len;
    for (int i = 0; i < 16; i++) begin m_imem[i] = 0; m_dmem[i] = 0; end
    bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.run = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Readback of a written dmem word through miso.
    send_frame(frm(2'b01, 4'h5, 8'hA5), 14);
    send_frame(frm(2'b10, 4'h5, 8'h00), 14);
    send_frame(frm(2'b11, 4'h0, 8'h00), 14);
    check("rb_first8", last_rx[31:24], 8'hA5);

    // Short frame flags an error and writes nothing; the next frame clears it.
    send_frame(32'h15F, 10);
    check("short_ferr", bus.frame_err, 1);
    send_frame(frm(2'b10, 4'h5, 8'h00), 14);
    check("short_clear", bus.frame_err, 0);
    send_frame(frm(2'b11, 4'h0, 8'h00), 14);
    check("short_dmem", last_rx[31:24], 8'hA5);
    send_frame(32'h3FFF, 16);
    check("long_ferr", bus.frame_err, 1);

    // Countdown program.
    send_frame(frm(2'b00, 4'h0, 8'h37), 14);
    send_frame(frm(2'b00, 4'h1, 8'hF6), 14);
    send_frame(frm(2'b00, 4'h2, 8'h1A), 14);
    send_frame(frm(2'b00, 4'h3, 8'h0D), 14);
    do_run(100, n, fin);
    check("prog_n", n, 8);
    check("prog_done", bus.done, 1);
    check("prog_acc", bus.acc_out, 8'h00);
    check("prog_pc", bus.pc_out, 3);
    check("prog_cnt", bus.cycle_cnt, 8);
    end_run();

    // Abort after two instructions.
    do_run(2, n, fin);
    check("abort_pc", bus.pc_out, 0);
    check("abort_acc", bus.acc_out, 2);
    check("abort_busy", bus.busy, 0);

    // Asynchronous reset in the middle of a run.
    q_exp.delete();
    @(negedge clk);
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    bus.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_tx = 0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_idle_busy", bus.busy, 0);
    check("midrst_idle_done", bus.done, 0);

    // Fall off the end of imem.
    send_frame(frm(2'b00, 4'h0, 8'h77), 14);
    for (int a = 1; a < 5; a++) send_frame(frm(2'b00, 4'(a), 8'h08), 14);
    for (int a = 5; a < 16; a++) send_frame(frm(2'b00, 4'(a), 8'h0E), 14);
    do_run(100, n, fin);
    check("edge_acc", bus.acc_out, 8'h70);
    check("edge_pc", bus.pc_out, 15);
    check("edge_cnt", bus.cycle_cnt, 16);
    check("edge_done", bus.done, 1);
    end_run();

    // Random programs and frames.
    for (int a = 0; a < 16; a++) send_frame(frm(2'b01, 4'(a), 8'($urandom)), 14);
    for (int p = 0; p < 12; p++) begin
      for (int a = 0; a < 16; a++) send_frame(frm(2'b00, 4'(a), 8'($urandom)), 14);
      do_run(40, n, fin);
      if (fin) end_run();
      ra = 4'($urandom);
      send_frame(frm(2'b10, ra, 8'h00), 14);
      send_frame(frm(2'b11, 4'h0, 8'h00), 14);
      len = $urandom_range(10, 16);
      send_frame($urandom, len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
